// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the even parity bit after the data bits.
module uart_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bit_period,
    input  logic [3:0]  data_size,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] timer_q, timer_d;
    logic [13:0] period_q, period_d;
    logic [3:0]  size_q, size_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_out_q, tx_out_d;
    logic        bit_end;
    logic [13:0] period_eff;
    logic [3:0]  size_eff;

`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
    logic [7:0]  data_mask;

    always_comb begin
        case (size_eff)
            4'd5:    data_mask = 8'h1F;
            4'd6:    data_mask = 8'h3F;
            4'd7:    data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    end
`endif

    assign period_eff = (bit_period < 14'd2) ? 14'd2 : bit_period;
    assign size_eff   = (data_size >= 4'd5 && data_size <= 4'd8) ? data_size : 4'd8;
    assign bit_end    = (timer_q == period_q - 14'd1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        period_d  = period_q;
        size_d    = size_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    period_d  = period_eff;
                    size_d    = size_eff;
                    timer_d   = 14'd0;
                    bit_cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^(tx_data & data_mask);
`endif
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = 14'd0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + 14'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d   = 14'd0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == size_q - 4'd1) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + 14'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    timer_d = 14'd0;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + 14'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    timer_d = 14'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 14'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level is derived from the next state so it changes on the same edge as the state.
    always_comb begin
        case (state_d)
            S_START: tx_out_d = 1'b0;
            S_DATA:  tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_out_d = parity_d;
`endif
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= 14'd0;
            period_q  <= 14'd2;
            size_q    <= 4'd8;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            tx_out_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            size_q    <= size_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_out_q  <= tx_out_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_done  = (state_q == S_STOP) && bit_end;
    assign tx_out   = tx_out_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line bits are queued at launch and checked cycle by cycle.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] bit_period;
    logic [3:0]  data_size;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready, tx_busy, tx_done, tx_out;

    typedef struct {
        logic val;
        int   len;
        bit   last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .bit_period (bit_period),
        .data_size  (data_size),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_out     (tx_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int p, input int n);
        exp_t e;
        logic [7:0] dv;
        logic par;
        dv  = d;
        par = 1'b0;
        e.len = p; e.last = 1'b0;
        e.val = 1'b0; sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.val = dv[i];
            par   = par ^ dv[i];
            sb.push_back(e);
        end
`ifdef UART_TX_PARITY_EN
        e.val = par; sb.push_back(e);
`endif
        e.val = 1'b1; e.last = 1'b1; sb.push_back(e);
    endtask

    // Called just after a negedge with the DUT idle; accept happens on the next posedge.
    task automatic launch(input logic [7:0] d, input logic [13:0] bp, input logic [3:0] ds,
                          input bit hold, input int pe, input int ne);
        tx_data    = d;
        bit_period = bp;
        data_size  = ds;
        tx_valid   = 1'b1;
        check("ready_before_accept", tx_ready, 1'b1);
        push_frame(d, pe, ne);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, output int cycles);
        exp_t e;
        bit fin;
        fin    = 1'b0;
        cycles = 0;
        while (!fin && sb.size() > 0) begin
            e = sb.pop_front();
            for (int c = 0; c < e.len; c++) begin
                @(negedge clk);
                cycles++;
                check({tag, "_out"},   tx_out,   e.val);
                check({tag, "_busy"},  tx_busy,  1'b1);
                check({tag, "_ready"}, tx_ready, 1'b0);
                check({tag, "_done"},  tx_done,  (e.last && c == e.len - 1));
            end
            fin = e.last;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_out"},   tx_out,   1'b1);
        check({tag, "_ready"}, tx_ready, 1'b1);
        check({tag, "_busy"},  tx_busy,  1'b0);
        check({tag, "_done"},  tx_done,  1'b0);
    endtask

`ifdef UART_TX_PARITY_EN
    localparam int XB = 1;
`else
    localparam int XB = 0;
`endif

    initial begin
        rst        = 1'b1;
        bit_period = 14'd4;
        data_size  = 4'd8;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Reset in the middle of DATA abandons the frame.
        launch(8'hA5, 14'd4, 4'd8, 1'b0, 4, 8);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", tx_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("in_reset_out", tx_out, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_idle("post_reset");

        launch(8'hA5, 14'd4, 4'd8, 1'b0, 4, 8);
        check_frame("a5", ncyc);
        check("a5_len", ncyc[15:0], 16'(4 * (10 + XB)));
        check_idle("a5_after");

        launch(8'hFF, 14'd10, 4'd5, 1'b0, 10, 5);
        check_frame("ff5", ncyc);
        check("ff5_len", ncyc[15:0], 16'(10 * (7 + XB)));
        check_idle("ff5_after");

        launch(8'h13, 14'd2, 4'd7, 1'b0, 2, 7);
        check_frame("x13", ncyc);
        check("x13_len", ncyc[15:0], 16'(2 * (9 + XB)));
        check_idle("x13_after");

        launch(8'h6C, 14'd1, 4'd0, 1'b0, 2, 8);
        check_frame("bp1", ncyc);
        check("bp1_len", ncyc[15:0], 16'(2 * (10 + XB)));
        check_idle("bp1_after");

        launch(8'h39, 14'd0, 4'd12, 1'b0, 2, 8);
        check_frame("bp0", ncyc);
        check("bp0_len", ncyc[15:0], 16'(2 * (10 + XB)));
        check_idle("bp0_after");

        // Back-to-back with a mid-frame config change that must only affect the next frame.
        launch(8'h00, 14'd3, 4'd8, 1'b1, 3, 8);
        tx_data    = 8'hFF;
        bit_period = 14'd5;
        data_size  = 4'd6;
        check_frame("b2b1", ncyc);
        check("b2b1_len", ncyc[15:0], 16'(3 * (10 + XB)));
        @(negedge clk);
        check("b2b_gap_out",   tx_out,   1'b1);
        check("b2b_gap_ready", tx_ready, 1'b1);
        push_frame(8'hFF, 5, 6);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_frame("b2b2", ncyc);
        check("b2b2_len", ncyc[15:0], 16'(5 * (8 + XB)));
        check_idle("b2b_after");
        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
